// File: rtl/audio_fft_pkg.sv
// Shared definitions for the audio FFT path.
//   FRAME_LEN   : samples per FFT frame (one RAM bank)
//   SAMPLE_W    : width of one channel sample inside a RAM word
//   rfr_state_t : state encoding of ram_frame_reader
package audio_fft_pkg;

  localparam int FRAME_LEN = 512;
  localparam int SAMPLE_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } rfr_state_t;

endpackage

// File: rtl/ram_frame_reader.sv
// Reads one full frame from the sample RAM bank the writer just filled and
// streams it to the FFT as a valid/ready/last word stream. It queues one
// pending frame so ping-pong banks run with a single bubble between frames.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   frame_rdy, frame_bank    pulse: bank frame_bank has been filled
//   rd_addr, rd_data         RAM read port (async read, same-cycle data)
//   m_tdata/m_tvalid/m_tready/m_tlast   output stream
//   frame_done, done_bank    pulse after the last beat; bank handed back
//   overrun                  pulse: a frame_rdy was dropped (queue full)
//   overrun_cnt              saturating drop count (RFR_OVERRUN_CNT_EN only)
//
// Optional feature macro: RFR_OVERRUN_CNT_EN
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no frame in progress, waiting for frame_rdy
// LOAD   | rd_addr = {cur_bank, 0}; word 0 is registered into m_tdata
// STREAM | presenting words; next word is fetched on every beat
module ram_frame_reader
  import audio_fft_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LOG2 = ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_rdy,
  input  logic                  frame_bank,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  frame_done,
  output logic                  done_bank,
  output logic                  overrun
`ifdef RFR_OVERRUN_CNT_EN
  ,
  output logic [15:0]           overrun_cnt
`endif
);

  localparam logic [FRAME_LOG2-1:0] IDX_LAST = {FRAME_LOG2{1'b1}};

  rfr_state_t            state, state_nxt;
  logic [FRAME_LOG2-1:0] idx;
  logic                  cur_bank;
  logic                  pend_vld, pend_bank;

  logic                  beat, last_beat;
  logic                  start, start_bank;
  logic                  pend_vld_nxt, pend_bank_nxt;
  logic                  drop;

  assign rd_addr = {cur_bank, idx};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    beat          = m_tvalid & m_tready;
    last_beat     = (state == STREAM) & beat & m_tlast;
    state_nxt     = state;
    start         = 1'b0;
    start_bank    = cur_bank;
    pend_vld_nxt  = pend_vld;
    pend_bank_nxt = pend_bank;
    drop          = 1'b0;

    case (state)
      IDLE: begin
        if (pend_vld) begin
          // a held entry goes first; a simultaneous frame_rdy refills the slot
          start         = 1'b1;
          start_bank    = pend_bank;
          pend_vld_nxt  = frame_rdy;
          pend_bank_nxt = frame_bank;
        end else if (frame_rdy) begin
          start      = 1'b1;
          start_bank = frame_bank;
        end
      end
      LOAD, STREAM: begin
        if (last_beat) begin
          if (pend_vld) begin
            // the slot was full when frame_rdy arrived, so it is dropped
            start        = 1'b1;
            start_bank   = pend_bank;
            pend_vld_nxt = 1'b0;
            drop         = frame_rdy;
          end else if (frame_rdy) begin
            // new bank passes straight through the empty slot
            start      = 1'b1;
            start_bank = frame_bank;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          if (state == LOAD) state_nxt = STREAM;
          if (frame_rdy) begin
            if (pend_vld) begin
              drop = 1'b1;
            end else begin
              pend_vld_nxt  = 1'b1;
              pend_bank_nxt = frame_bank;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (start) state_nxt = LOAD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      cur_bank   <= 1'b0;
      pend_vld   <= 1'b0;
      pend_bank  <= 1'b0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      frame_done <= 1'b0;
      done_bank  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= drop;
      pend_vld   <= pend_vld_nxt;
      pend_bank  <= pend_bank_nxt;

      case (state)
        LOAD: begin
          m_tdata  <= rd_data;
          m_tvalid <= 1'b1;
          m_tlast  <= 1'b0;
          idx      <= FRAME_LOG2'(1);
        end
        STREAM: begin
          if (beat) begin
            if (m_tlast) begin
              m_tvalid   <= 1'b0;
              m_tlast    <= 1'b0;
              frame_done <= 1'b1;
              done_bank  <= cur_bank;
            end else begin
              m_tdata <= rd_data;
              m_tlast <= (idx == IDX_LAST);
              // idx parks on the last word; only a LOAD reload wraps it
              if (idx != IDX_LAST) idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (start) begin
        cur_bank <= start_bank;
        idx      <= '0;
      end
    end
  end

`ifdef RFR_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                               overrun_cnt <= '0;
    else if (drop && overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ram_frame_reader.sv
// Self-checking bench for ram_frame_reader. A RAM array with asynchronous
// read feeds the DUT; a stream monitor compares every accepted word against
// the RAM contents of the bank expected to be streaming, frame by frame.
module tb_ram_frame_reader;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int FL = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_rdy = 1'b0;
  logic          frame_bank = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic          frame_done;
  logic          done_bank;
  logic          overrun;
`ifdef RFR_OVERRUN_CNT_EN
  logic [15:0]   overrun_cnt;
`endif

  logic [DW-1:0] ram [0:1023];
  int n_checks = 0;
  int n_fail   = 0;
  bit ready_rand = 1'b0;

  always #5 clk = ~clk;

  assign rd_data = ram[rd_addr];

  ram_frame_reader dut (
    .clk        (clk),
    .rst        (rst),
    .frame_rdy  (frame_rdy),
    .frame_bank (frame_bank),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .frame_done (frame_done),
    .done_bank  (done_bank),
    .overrun    (overrun)
`ifdef RFR_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // reference model: queue of banks expected to stream, in order
  bit          exp_banks[$];
  int          k = 0;
  bit          done_due = 1'b0;
  bit          done_bank_exp = 1'b0;
  bit          in_gap = 1'b0;
  int          gap_cnt = 0;
  int          last_gap = -1;
  int          ovr_seen = 0;
  int          last_seen = 0;
  int          beats = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] last_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_banks.delete();
      k          = 0;
      done_due   = 1'b0;
      in_gap     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (done_due) begin
        check_val("frame_done", frame_done, 1);
        check_val("done_bank", done_bank, done_bank_exp);
        done_due = 1'b0;
      end else if (frame_done) begin
        check_val("spurious_done", frame_done, 0);
      end
      if (overrun) ovr_seen++;
      if (prev_stall) begin
        check_val("hold_valid", m_tvalid, 1);
        check_val("hold_data", m_tdata, prev_data);
      end
      if (in_gap) begin
        if (m_tvalid) begin
          last_gap = gap_cnt;
          in_gap   = 1'b0;
        end else begin
          gap_cnt++;
        end
      end
      if (m_tvalid && m_tready) begin
        beats++;
        if (exp_banks.size() == 0) begin
          check_val("unexpected_beat", m_tvalid, 0);
        end else begin
          check_val("data", m_tdata, ram[{exp_banks[0], 9'(k)}]);
          check_val("last", m_tlast, (k == FL - 1));
          if (m_tlast) begin
            last_seen++;
            last_data = m_tdata;
          end
          k++;
          if (k == FL) begin
            k             = 0;
            done_bank_exp = exp_banks.pop_front();
            done_due      = 1'b1;
            in_gap        = 1'b1;
            gap_cnt       = 0;
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  task automatic pulse_rdy(input bit b);
    @(posedge clk);
    #1;
    frame_rdy  = 1'b1;
    frame_bank = b;
    @(posedge clk);
    #1;
    frame_rdy  = 1'b0;
  endtask

  task automatic wait_word(input int w, input int budget);
    int n;
    n = 0;
    while (!(k == w && m_tvalid) && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check_val("wait_word", k, w);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_banks.size() != 0 || done_due) && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check_val(tag, exp_banks.size(), 0);
    repeat (3) @(negedge clk);
    #2;
  endtask

  initial begin
    int o0, b0, l0, n;

    for (int a = 0; a < 1024; a++) ram[a] = {16'(a % 512), ~16'(a % 512)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_tvalid", m_tvalid, 0);
    check_val("rst_tlast", m_tlast, 0);
    check_val("rst_frame_done", frame_done, 0);
    check_val("rst_overrun", overrun, 0);
    check_val("rst_tdata", m_tdata, 0);
    check_val("rst_rd_addr", rd_addr, 0);
    check_val("rst_done_bank", done_bank, 0);
`ifdef RFR_OVERRUN_CNT_EN
    check_val("rst_overrun_cnt", overrun_cnt, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single frame from bank 1, ready always high
    l0 = last_seen;
    exp_banks.push_back(1'b1);
    pulse_rdy(1'b1);
    @(negedge clk);
    check_val("load_addr", rd_addr, 512);
    check_val("latency_not_yet", m_tvalid, 0);
    @(negedge clk);
    check_val("latency_valid", m_tvalid, 1);
    check_val("first_word", m_tdata, {16'd0, 16'hFFFF});
    wait_drain("drain_single", 700);
    check_val("single_last_cnt", last_seen - l0, 1);
    check_val("last_word", last_data, {16'd511, ~16'd511});

    for (int a = 0; a < 1024; a++) ram[a] = $urandom;

    // random backpressure
    ready_rand = 1'b1;
    b0 = beats;
    l0 = last_seen;
    exp_banks.push_back(1'b0);
    pulse_rdy(1'b0);
    wait_drain("drain_random", 4000);
    check_val("random_beats", beats - b0, FL);
    check_val("random_last_cnt", last_seen - l0, 1);
    ready_rand = 1'b0;
    @(posedge clk);
    #1;

    // pending frame queued mid-frame: one bubble between frames
    o0 = ovr_seen;
    last_gap = -1;
    exp_banks.push_back(1'b0);
    exp_banks.push_back(1'b1);
    pulse_rdy(1'b0);
    wait_word(100, 300);
    pulse_rdy(1'b1);
    wait_drain("drain_pingpong", 1500);
    check_val("pingpong_gap", last_gap, 1);
    check_val("pingpong_no_ovr", ovr_seen - o0, 0);

    // two extra pulses during one frame: second one overruns
    o0 = ovr_seen;
    exp_banks.push_back(1'b0);
    exp_banks.push_back(1'b1);
    pulse_rdy(1'b0);
    wait_word(50, 300);
    pulse_rdy(1'b1);
    wait_word(150, 300);
    pulse_rdy(1'b0);
    @(negedge clk);
    check_val("overrun_pulse", overrun, 1);
    @(negedge clk);
    check_val("overrun_one_cycle", overrun, 0);
    wait_drain("drain_overrun", 1500);
    check_val("overrun_count_seen", ovr_seen - o0, 1);
`ifdef RFR_OVERRUN_CNT_EN
    check_val("overrun_cnt", overrun_cnt, 1);
`endif

    // frame_rdy coincident with the last-beat handshake
    o0 = ovr_seen;
    last_gap = -1;
    exp_banks.push_back(1'b0);
    exp_banks.push_back(1'b1);
    pulse_rdy(1'b0);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!(m_tvalid && m_tlast) && n < 700);
    check_val("coincide_reach_last", m_tlast, 1);
    frame_rdy  = 1'b1;
    frame_bank = 1'b1;
    @(posedge clk);
    #1;
    frame_rdy  = 1'b0;
    wait_drain("drain_coincide", 1500);
    check_val("coincide_gap", last_gap, 1);
    check_val("coincide_no_ovr", ovr_seen - o0, 0);

    // reset mid-frame with a pending entry held
    exp_banks.push_back(1'b0);
    pulse_rdy(1'b0);
    wait_word(100, 300);
    pulse_rdy(1'b1);
    wait_word(300, 400);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2;
    check_val("midrst_tvalid", m_tvalid, 0);
    check_val("midrst_tlast", m_tlast, 0);
    check_val("midrst_frame_done", frame_done, 0);
    check_val("midrst_overrun", overrun, 0);
    check_val("midrst_tdata", m_tdata, 0);
    check_val("midrst_rd_addr", rd_addr, 0);
    check_val("midrst_done_bank", done_bank, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    check_val("no_pending_after_rst", m_tvalid, 0);
    check_val("no_done_after_rst", frame_done, 0);
    b0 = beats;
    exp_banks.push_back(1'b1);
    pulse_rdy(1'b1);
    wait_drain("drain_after_rst", 700);
    check_val("after_rst_beats", beats - b0, FL);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_frame_reader.md
# ram_frame_reader

Downstream consumer of the 1024x32 distributed sample RAM in the audio FFT path. The block reads one 512-word frame from the RAM half (bank) that the upstream writer has just filled, and streams it to the FFT input as a valid/ready/last word stream. When the last word is accepted it hands the bank back to the writer. It also queues one pending frame, so ping-pong operation sees at most a one-cycle bubble between frames.

## Interface
Parameters:
- ADDR_WIDTH, 10, RAM address width; MSB selects the bank
- DATA_WIDTH, 32, RAM word width, {left[15:0], right[15:0]}
- FRAME_LOG2, ADDR_WIDTH-1, log2 of frame length; must equal ADDR_WIDTH-1

Ports:
- clk  in  1  single clock; drives this block and both RAM clocks
- rst  in  1  synchronous, active-high reset
- frame_rdy  in  1  one-cycle pulse: bank frame_bank is full
- frame_bank  in  1  bank index; qualified by frame_rdy
- rd_addr  out  ADDR_WIDTH  RAM read address, {cur_bank, idx}; combinational from registers
- rd_data  in  DATA_WIDTH  RAM read data; unregistered, valid in the same cycle as rd_addr
- m_tdata  out  DATA_WIDTH  stream data
- m_tvalid  out  1  stream valid
- m_tready  in  1  stream ready from FFT
- m_tlast  out  1  high with the final word (index 511) of a frame
- frame_done  out  1  one-cycle pulse after the last beat is accepted
- done_bank  out  1  bank released; held from frame_done until the next frame_done
- overrun  out  1  one-cycle pulse: a frame_rdy was dropped
- overrun_cnt  out  16  saturating count of dropped frames; present only with RFR_OVERRUN_CNT_EN

## Operation
- The FSM has three states: IDLE, LOAD, STREAM. Reset state is IDLE.
- IDLE -> LOAD:
  - Taken on frame_rdy, or on a held pending entry.
  - Latches cur_bank and sets idx=0.
- LOAD:
  - Drives rd_addr={cur_bank,0}.
  - Registers m_tdata<=rd_data and m_tvalid<=1.
  - Sets m_tlast<=0 and idx<=1, then goes to STREAM.
- STREAM:
  - On a beat (m_tvalid&m_tready) with m_tlast=0: m_tdata<=rd_data at {cur_bank,idx}, m_tlast<=(idx==511), idx<=idx+1.
  - On a beat with m_tlast=1:
    - m_tvalid<=0, m_tlast<=0, frame_done<=1, done_bank<=cur_bank.
    - Next state is LOAD with the pending bank if one is held (pending cleared), otherwise IDLE.
  - With no beat, m_tdata, m_tlast and idx hold. m_tvalid never drops until the last beat completes.
- Pending queue, one entry:
  - A frame_rdy outside IDLE is stored if the queue is empty.
  - A frame_rdy while the queue is full is dropped and pulses overrun the next cycle. The held entry is kept.
- frame_rdy in the same cycle as the last beat:
  - The new bank becomes the pending entry and is taken immediately: next state LOAD with that bank.
  - If the queue was already full, the new one is dropped as an overrun.
- The idx counter is FRAME_LOG2 bits wide and wraps 511->0 only through the LOAD reload, never mid-frame.
- rd_data is passed through unmodified; the block does no arithmetic on samples.

## Timing
- Reset values: m_tvalid, m_tlast, frame_done and overrun are 0. m_tdata, idx, cur_bank, done_bank and overrun_cnt are 0. rd_addr is 0. Pending queue is empty.
- Reset mid-frame aborts the frame. No frame_done is issued, and the pending entry is discarded.
- Latency: frame_rdy sampled at edge T -> LOAD during cycle T+1 -> m_tvalid=1 with word 0 after edge T+2.
- Throughput: one word per cycle while m_tready=1. A frame takes 512 beats, plus 1 LOAD cycle.
- Back-to-back frames from the pending queue give exactly one cycle with m_tvalid=0.
- frame_done is asserted the cycle after the last beat. done_bank is valid in that same cycle.
- m_tdata is stable whenever m_tvalid=1 and m_tready=0.

## Configuration
- RFR_OVERRUN_CNT_EN defined:
  - The overrun_cnt port exists.
  - It increments on each overrun pulse and saturates at 16'hFFFF.
  - It clears only on rst.
- RFR_OVERRUN_CNT_EN undefined: the port and the counter are absent. The overrun pulse is always present.

## Structure
- Shared package audio_fft_pkg holds:
  - FRAME_LEN = 512 and SAMPLE_W = 16
  - the state enum rfr_state_t {IDLE, LOAD, STREAM}
- Single module. No sub-module is needed; the pending queue is a valid bit plus a bank bit.
- The RAM is instantiated by the parent. wr_clk and rd_clk are both tied to clk there.

## Test plan
- Single frame, m_tready=1, RAM word k = {k,~k}, frame_rdy with bank 1:
  - First m_tvalid 2 cycles later, with rd_addr=512.
  - 512 consecutive beats; m_tlast on data {511,~511}.
  - frame_done with done_bank=1 one cycle after the last beat.
- Random m_tready at 50% duty: m_tdata holds while stalled, all 512 words arrive in order, exactly one m_tlast.
- frame_rdy bank 1 at word 100 of a bank 0 frame:
  - After bank 0's last beat, exactly one idle cycle.
  - Then bank 1 word 0 from address 512.
- Two extra frame_rdy pulses during one frame:
  - The second pulse produces overrun one cycle later.
  - overrun_cnt=1 (macro on); only the first queued frame is streamed.
- frame_rdy coincident with the last-beat handshake, queue empty: the next frame starts via LOAD with one bubble and no overrun.
- rst asserted at word 300: all outputs return to reset values the next cycle, with no frame_done. A new frame_rdy then streams from word 0.
